// File: rtl/fsm_line_pkg.sv
// Shared definitions for the fill/seal line controllers: state encodings,
// fault codes and a small sizing helper for the timeout counter.
package fsm_line_pkg;

  // Sequencer states; code 3'd7 is deliberately left unused.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL_REQ  = 3'd1,
    ST_FILL_WAIT = 3'd2,
    ST_SEAL_WAIT = 3'd3,
    ST_NEXT      = 3'd4,
    ST_DONE      = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  // Latched reason for entering FAULT.
  typedef enum logic [1:0] {
    FC_NONE         = 2'b00,
    FC_FILL_TIMEOUT = 2'b01,
    FC_SEAL_TIMEOUT = 2'b10,
    FC_PROTOCOL     = 2'b11
  } fault_code_t;

  // Container counter ceiling; the count sticks here rather than wrapping.
  localparam logic [7:0] COUNT_MAX = 8'd255;

  // Timer width that can represent (larger timeout - 1), never below 1 bit.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating up-counter used to time the fill and seal phases. A clear
// restarts it at zero; otherwise it climbs by one per cycle and parks at
// all-ones.
module seq_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);

  // Count up each cycle, restart on clear, hold at the ceiling.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, independent of block ordering.
    if (!rst || clear) begin
      value <= '0;
    end else if (value != '1) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/fill_seal_sequencer.sv
// Batch sequencer for a fill-then-seal line. Each container is one fill
// request to the filler station followed by a wait for the sealer to accept
// the product. Both waits are guarded by timeouts; a sealer handshake seen
// while still filling is a protocol error. All outputs are registers.
module fill_seal_sequencer
  import fsm_line_pkg::*;
#(
  parameter int BATCH_SIZE   = 8,
  parameter int FILL_TIMEOUT = 1000,
  parameter int SEAL_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       lleno_flag,
  input  logic       productook,
  input  logic       fault_clr,
  output logic       startfill,
  output logic       seal_phase,
  output logic       busy,
  output logic       batch_done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] count,
  output logic [2:0] state_indicator
);

  localparam int             TW         = timer_width(FILL_TIMEOUT, SEAL_TIMEOUT);
  localparam logic [TW-1:0]  FILL_LAST  = TW'(FILL_TIMEOUT - 1);
  localparam logic [TW-1:0]  SEAL_LAST  = TW'(SEAL_TIMEOUT - 1);
  localparam logic [7:0]     BATCH_LAST = 8'(BATCH_SIZE);

  state_t      state, state_nxt;
  fault_code_t code_q, code_nxt;
  logic [7:0]  count_nxt;
  logic [TW-1:0] timer;
  logic        timer_clear;

  // Any state change restarts the phase timer, so each wait is timed from
  // its own entry.
  assign timer_clear = (state_nxt != state);

  seq_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .value (timer)
  );

  // Next-state, next-count and next-fault-code decision.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    code_nxt  = code_q;
    count_nxt = count;
    case (state)
      ST_IDLE: begin
        if (start) begin
          count_nxt = '0;
          state_nxt = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: state_nxt = ST_FILL_WAIT;
      ST_FILL_WAIT: begin
        // A sealer handshake while filling outranks a simultaneous fill-done.
        if (productook) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_PROTOCOL;
        end else if (lleno_flag) begin
          state_nxt = ST_SEAL_WAIT;
        end else if (timer == FILL_LAST) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_FILL_TIMEOUT;
        end
      end
      ST_SEAL_WAIT: begin
        if (productook) begin
          count_nxt = (count == COUNT_MAX) ? count : count + 8'd1;
          state_nxt = ST_NEXT;
        end else if (timer == SEAL_LAST) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_SEAL_TIMEOUT;
        end
      end
      ST_NEXT: begin
        // A full batch finishes normally even if stop is also requested.
        if (count == BATCH_LAST) begin
          state_nxt = ST_DONE;
        end else if (stop) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_FILL_REQ;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_FAULT: begin
        if (fault_clr) begin
          state_nxt = ST_IDLE;
          code_nxt  = FC_NONE;
        end
      end
      default: state_nxt = ST_IDLE;  // unused code 7 falls back to IDLE
    endcase
  end

  // State register plus outputs registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      code_q     <= FC_NONE;
      count      <= '0;
      startfill  <= 1'b0;
      seal_phase <= 1'b0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      code_q     <= code_nxt;
      count      <= count_nxt;
      startfill  <= (state_nxt == ST_FILL_REQ);
      // seal_phase freezes at its current value while sitting in FAULT.
      seal_phase <= (state_nxt == ST_SEAL_WAIT) ||
                    ((state_nxt == ST_FAULT) && seal_phase);
      busy       <= state_nxt inside {ST_FILL_REQ, ST_FILL_WAIT, ST_SEAL_WAIT,
                                      ST_NEXT, ST_DONE};
      batch_done <= (state_nxt == ST_DONE);
      fault      <= (state_nxt == ST_FAULT);
    end
  end

  assign fault_code      = code_q;
  assign state_indicator = state;

endmodule

// File: tb/tb_fill_seal_sequencer.sv
// Self-checking bench for fill_seal_sequencer. The bench plays the filler
// and sealer stations; each container is described by its fill delay, its
// seal delay and optional protocol-error / stop requests, and the expected
// outcome is worked out from the timeout rules before the container runs.
module tb_fill_seal_sequencer;

  localparam int BATCH = 3;
  localparam int FT    = 10;
  localparam int ST    = 6;

  // Container outcomes as seen by the bench
  localparam int OC_NEXT    = 0;
  localparam int OC_DONE    = 1;
  localparam int OC_STOPPED = 2;
  localparam int OC_FAULT   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, lleno_flag = 1'b0;
  logic       productook = 1'b0, fault_clr = 1'b0;
  logic       startfill, seal_phase, busy, batch_done, fault;
  logic [1:0] fault_code;
  logic [7:0] count;
  logic [2:0] state_indicator;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  int oc;

  fill_seal_sequencer #(
    .BATCH_SIZE   (BATCH),
    .FILL_TIMEOUT (FT),
    .SEAL_TIMEOUT (ST)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stop            (stop),
    .lleno_flag      (lleno_flag),
    .productook      (productook),
    .fault_clr       (fault_clr),
    .startfill       (startfill),
    .seal_phase      (seal_phase),
    .busy            (busy),
    .batch_done      (batch_done),
    .fault           (fault),
    .fault_code      (fault_code),
    .count           (count),
    .state_indicator (state_indicator)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "/state"},      state_indicator, 0);
    check({tag, "/busy"},       busy, 0);
    check({tag, "/fault"},      fault, 0);
    check({tag, "/fault_code"}, fault_code, 0);
    check({tag, "/startfill"},  startfill, 0);
    check({tag, "/seal_phase"}, seal_phase, 0);
    check({tag, "/batch_done"}, batch_done, 0);
    check({tag, "/count"},      count, exp_count);
  endtask

  // From IDLE: raise start for one edge; FILL_REQ becomes visible.
  task automatic start_batch(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_count = 0;
    check({tag, "/count_cleared"}, count, 0);
  endtask

  // Runs one container starting from a visible FILL_REQ.
  //   d: cycles after the startfill pulse at which lleno_flag is raised
  //   p: cycles of seal wait at which productook is raised
  // The filler is accepted within FT cycles, the sealer within ST cycles.
  task automatic run_container(input string tag, input int d, input int p,
                               input bit perr, input bit stop_req, output int outcome);
    int fill_end, seal_end;
    fill_end = (d <= FT) ? d : FT;
    seal_end = (p <= ST) ? p : ST;
    check({tag, "/startfill"}, startfill, 1);
    check({tag, "/fill_req_state"}, state_indicator, 1);
    if (stop_req) stop = 1'b1;
    for (int k = 1; k <= fill_end; k++) begin
      tick();
      if (state_indicator !== 3'd2 || startfill !== 1'b0 || seal_phase !== 1'b0 || busy !== 1'b1)
        check({tag, "/fill_wait"}, {startfill, seal_phase, busy, state_indicator}, {1'b0, 1'b0, 1'b1, 3'd2});
      lleno_flag = (k == d);
      productook = perr && (k == d);
    end
    tick();
    lleno_flag = 1'b0;
    productook = 1'b0;
    if (d > FT || perr) begin
      check({tag, "/fault"}, fault, 1);
      check({tag, "/fault_code"}, fault_code, (d > FT) ? 1 : 3);
      check({tag, "/fault_state"}, state_indicator, 6);
      check({tag, "/fault_busy"}, busy, 0);
      check({tag, "/fault_seal"}, seal_phase, 0);
      outcome = OC_FAULT;
      return;
    end
    for (int j = 1; j <= seal_end; j++) begin
      if (state_indicator !== 3'd3 || seal_phase !== 1'b1 || busy !== 1'b1 || fault !== 1'b0)
        check({tag, "/seal_wait"}, {seal_phase, busy, fault, state_indicator}, {1'b1, 1'b1, 1'b0, 3'd3});
      productook = (j == p);
      tick();
      productook = 1'b0;
    end
    if (p > ST) begin
      check({tag, "/fault"}, fault, 1);
      check({tag, "/fault_code"}, fault_code, 2);
      check({tag, "/fault_seal_held"}, seal_phase, 1);
      check({tag, "/count_kept"}, count, exp_count);
      outcome = OC_FAULT;
      return;
    end
    exp_count++;
    check({tag, "/next_state"}, state_indicator, 4);
    check({tag, "/count"}, count, exp_count);
    check({tag, "/next_seal"}, seal_phase, 0);
    tick();
    if (exp_count == BATCH) begin
      check({tag, "/done_state"}, state_indicator, 5);
      check({tag, "/batch_done"}, batch_done, 1);
      tick();
      stop = 1'b0;
      check_idle({tag, "/after_done"});
      outcome = OC_DONE;
    end else if (stop_req) begin
      stop = 1'b0;
      check_idle({tag, "/after_stop"});
      outcome = OC_STOPPED;
    end else begin
      outcome = OC_NEXT;
    end
  endtask

  // In FAULT: outputs hold, start is ignored, fault_clr returns to IDLE.
  task automatic fault_recover(input string tag, input int code, input bit seal_held);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (fault !== 1'b1 || fault_code !== code[1:0] || seal_phase !== seal_held || busy !== 1'b0)
        check({tag, "/fault_hold"}, {fault, fault_code, seal_phase, busy}, {1'b1, code[1:0], seal_held, 1'b0});
    end
    check({tag, "/count_hold"}, count, exp_count);
    start = 1'b0;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check_idle({tag, "/cleared"});
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    start = 1'b1;
    lleno_flag = 1'b1;
    productook = 1'b1;
    tick();
    tick();
    start = 1'b0;
    lleno_flag = 1'b0;
    productook = 1'b0;
    exp_count = 0;
    check_idle("reset");
    rst = 1'b1;
    tick();
    check_idle("idle_no_start");

    // Normal batch: fill done 5 cycles after startfill, seal 4 cycles later
    start_batch("normal");
    run_container("normal_c1", 5, 4, 0, 0, oc); check("normal_c1/outcome", oc, OC_NEXT);
    run_container("normal_c2", 5, 4, 0, 0, oc); check("normal_c2/outcome", oc, OC_NEXT);
    run_container("normal_c3", 5, 4, 0, 0, oc); check("normal_c3/outcome", oc, OC_DONE);
    tick();
    check("normal/count_holds", count, BATCH);

    // Fill timeout
    start_batch("fill_to");
    run_container("fill_to", FT + 5, 1, 0, 0, oc); check("fill_to/outcome", oc, OC_FAULT);
    fault_recover("fill_to", 1, 0);

    // Seal timeout: seal_phase stays high in FAULT
    start_batch("seal_to");
    run_container("seal_to", 3, ST + 4, 0, 0, oc); check("seal_to/outcome", oc, OC_FAULT);
    fault_recover("seal_to", 2, 1);

    // Boundaries: handshakes on the last accepted cycle
    start_batch("edge");
    run_container("edge_c1", FT, ST, 0, 0, oc); check("edge_c1/outcome", oc, OC_NEXT);
    run_container("edge_c2", 1, 1, 0, 0, oc);   check("edge_c2/outcome", oc, OC_NEXT);
    run_container("edge_c3", FT, 1, 0, 0, oc);  check("edge_c3/outcome", oc, OC_DONE);

    // Graceful stop during container 2
    start_batch("stop");
    run_container("stop_c1", 2, 3, 0, 0, oc); check("stop_c1/outcome", oc, OC_NEXT);
    run_container("stop_c2", 4, 2, 0, 1, oc); check("stop_c2/outcome", oc, OC_STOPPED);
    check("stop/count", count, 2);

    // Stop on the final container still completes the batch
    start_batch("stop_last");
    run_container("stop_last_c1", 1, 1, 0, 0, oc); check("stop_last_c1/outcome", oc, OC_NEXT);
    run_container("stop_last_c2", 2, 2, 0, 0, oc); check("stop_last_c2/outcome", oc, OC_NEXT);
    run_container("stop_last_c3", 3, 3, 0, 1, oc); check("stop_last_c3/outcome", oc, OC_DONE);

    // Protocol error: productook together with lleno_flag while filling
    start_batch("proto");
    run_container("proto", 3, 1, 1, 0, oc); check("proto/outcome", oc, OC_FAULT);
    fault_recover("proto", 3, 0);

    // Reset in SEAL_WAIT with a partly completed batch
    start_batch("midrst");
    run_container("midrst_c1", 2, 2, 0, 0, oc); check("midrst_c1/outcome", oc, OC_NEXT);
    run_container("midrst_c2", 2, 2, 0, 0, oc); check("midrst_c2/outcome", oc, OC_NEXT);
    tick();
    lleno_flag = 1'b1;
    tick();
    lleno_flag = 1'b0;
    check("midrst/in_seal", state_indicator, 3);
    check("midrst/count_before", count, 2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_count = 0;
    check_idle("midrst/after");

    // Reset while in FAULT overrides the latched fault
    start_batch("fltrst");
    run_container("fltrst", FT + 1, 1, 0, 0, oc); check("fltrst/outcome", oc, OC_FAULT);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_count = 0;
    check_idle("fltrst/after");

    // Randomized batches
    for (int b = 0; b < 40; b++) begin
      int d, p, ci;
      bit perr, stp;
      start_batch("rand");
      ci = 0;
      do begin
        d = ($urandom_range(0, 99) < 85) ? int'($urandom_range(1, FT)) : int'($urandom_range(FT + 1, FT + 3));
        p = ($urandom_range(0, 99) < 85) ? int'($urandom_range(1, ST)) : int'($urandom_range(ST + 1, ST + 3));
        perr = ($urandom_range(0, 11) == 0);
        stp  = ($urandom_range(0, 7) == 0);
        run_container($sformatf("rand_b%0d_c%0d", b, ci), d, p, perr, stp, oc);
        ci++;
      end while (oc == OC_NEXT);
      if (oc == OC_FAULT) begin
        fault_recover($sformatf("rand_b%0d", b), (d > FT) ? 1 : (perr ? 3 : 2), (d <= FT) && !perr);
      end
      stop = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fill_seal_sequencer.md
FILL_SEAL_SEQUENCER -- requirements
Module: fill_seal_sequencer

Interface
REQ-001 Parameter BATCH_SIZE, default 8: containers per batch, range 1..255.
REQ-002 Parameter FILL_TIMEOUT, default 1000: maximum cycles from startfill pulse to lleno_flag.
REQ-003 Parameter SEAL_TIMEOUT, default 1000: maximum cycles from seal phase entry to productook.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-low reset.
REQ-006 Port start  input  1  level; begins a batch when sampled high in IDLE.
REQ-007 Port stop  input  1  level; requests graceful halt after the current container.
REQ-008 Port lleno_flag  input  1  fill complete from the filler station.
REQ-009 Port productook  input  1  seal complete and product accepted by the sealer station.
REQ-010 Port fault_clr  input  1  acknowledges a fault and returns the block to IDLE.
REQ-011 Port startfill  output  1  one-cycle pulse commanding one fill.
REQ-012 Port seal_phase  output  1  high while waiting for productook.
REQ-013 Port busy  output  1  high in every state except IDLE and FAULT.
REQ-014 Port batch_done  output  1  one-cycle pulse when count reaches BATCH_SIZE.
REQ-015 Port fault  output  1  high in FAULT.
REQ-016 Port fault_code  output  2  00 none, 01 fill timeout, 10 seal timeout, 11 protocol error.
REQ-017 Port count  output  8  containers completed in the current batch.
REQ-018 Port state_indicator  output  3  encoded current state.

Function
REQ-019 States SHALL be IDLE=0, FILL_REQ=1, FILL_WAIT=2, SEAL_WAIT=3, NEXT=4, DONE=5, FAULT=6; code 7 SHALL be unreachable and SHALL recover to IDLE on the next cycle.
REQ-020 In IDLE with start=1, the block SHALL clear count and go to FILL_REQ.
REQ-021 FILL_REQ SHALL last exactly one cycle, drive startfill=1, clear the timer, and go to FILL_WAIT.
REQ-022 In FILL_WAIT, lleno_flag=1 SHALL move to SEAL_WAIT; otherwise, the timer reaching FILL_TIMEOUT-1 SHALL move to FAULT with code 01.
REQ-023 In SEAL_WAIT, seal_phase SHALL be 1; productook=1 SHALL increment count and move to NEXT; otherwise, the timer reaching SEAL_TIMEOUT-1 SHALL move to FAULT with code 10.
REQ-024 productook=1 in FILL_WAIT SHALL move to FAULT with code 11; if lleno_flag is also 1 in the same cycle, protocol error SHALL take priority.
REQ-025 In NEXT, count==BATCH_SIZE SHALL move to DONE; otherwise stop=1 SHALL move to IDLE; otherwise the block SHALL move to FILL_REQ.
REQ-026 DONE SHALL last one cycle, drive batch_done=1, and return to IDLE; count SHALL hold until the next start.
REQ-027 stop SHALL never abort FILL_WAIT or SEAL_WAIT.
REQ-028 In FAULT, outputs SHALL hold and fault_code SHALL be latched; fault_clr=1 SHALL go to IDLE and clear fault_code; start SHALL be ignored in FAULT.
REQ-029 The timer SHALL be wide enough for the larger timeout, SHALL saturate, and SHALL reset on every state change.
REQ-030 count SHALL saturate at 255 and never wrap.
REQ-031 All outputs SHALL be registered or decoded from the state register only, with no combinational input-to-output paths.

Reset
REQ-032 With rst=0 at a clock edge, the block SHALL enter IDLE with count=0, timer=0, fault_code=00, and startfill=seal_phase=busy=batch_done=fault=0.
REQ-033 Reset SHALL override every other input, including during FILL_WAIT and FAULT.

Structure
REQ-034 State encodings and fault_code values SHALL reside in the shared package fsm_line_pkg.
REQ-035 The timeout counter SHALL be a separate sub-module, seq_timer, with clear and saturating count.
REQ-036 The block SHALL be single-clock with no latches and no internal instantiation of the filler or sealer stations.

Verification
REQ-037 Normal batch: BATCH_SIZE=3, start=1, lleno_flag 5 cycles after each startfill, productook 4 cycles later -> 3 startfill pulses, count=3, one batch_done pulse, return to IDLE.
REQ-038 Fill timeout: FILL_TIMEOUT=10, lleno_flag held 0 -> FAULT exactly 10 cycles after the startfill pulse, fault_code=01; fault_clr -> IDLE.
REQ-039 Seal timeout: SEAL_TIMEOUT=6, productook held 0 -> FAULT, fault_code=10, seal_phase held 1.
REQ-040 Graceful stop: stop=1 asserted during SEAL_WAIT of container 2 of 8 -> productook is completed, count=2, IDLE, no batch_done.
REQ-041 Protocol error: productook=1 and lleno_flag=1 together in FILL_WAIT -> FAULT with fault_code=11.
REQ-042 Mid-operation reset: rst=0 for one cycle in SEAL_WAIT with count=4 -> IDLE next cycle, count=0, all outputs 0.
